// File: rtl/chunk_add_pkg.sv
// chunk_add_pkg: shared types and sizing for the chunked adder sequencer
package chunk_add_pkg;
  typedef enum logic [1:0] {ST_LOAD, ST_ADD, ST_DRAIN} state_t;
  localparam int CHUNK_W_DEF = 3;
  localparam int N_CHUNKS_DEF = 4;
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int IDX_W = idx_w(N_CHUNKS_DEF);
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational ripple-carry adder of one chunk width
module chunk_adder #(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic c;
  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/chunk_add_sequencer.sv
// chunk_add_sequencer: load operand chunks, ripple them through one shared chunk adder, stream the sum out
module chunk_add_sequencer
  import chunk_add_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int N_CHUNKS = N_CHUNKS_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] a_chunk,
  input  logic [CHUNK_W-1:0] b_chunk,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CHUNK_W-1:0] sum_chunk,
  output logic               out_last,
  output logic               carry_out,
  output logic               busy
);
  localparam int IW = idx_w(N_CHUNKS);
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic carry, carry_nx;
  logic [CHUNK_W-1:0] buf_a [N_CHUNKS];
  logic [CHUNK_W-1:0] buf_b [N_CHUNKS];
  logic [CHUNK_W-1:0] add_s;
  logic add_c, last, in_fire, out_fire;

  chunk_adder #(.W(CHUNK_W)) u_add (
    .a(buf_a[idx]),
    .b(buf_b[idx]),
    .cin(carry),
    .s(add_s),
    .cout(add_c)
  );

  assign last = idx == IW'(N_CHUNKS - 1);
  assign in_ready = !reset && state == ST_LOAD;
  assign out_valid = !reset && state == ST_DRAIN;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign sum_chunk = out_valid ? buf_a[idx] : '0;
  assign out_last = out_valid && last;
  assign carry_out = out_last && carry;
  assign busy = !reset && (state != ST_LOAD || idx != '0);

  always_comb begin
    state_nx = state;
    idx_nx = idx;
    carry_nx = carry;
    if (in_fire || out_fire || state == ST_ADD) idx_nx = last ? '0 : idx + IW'(1);
    case (state)
      ST_LOAD: if (in_fire && last) begin
        state_nx = ST_ADD;
        carry_nx = 1'b0;
      end
      ST_ADD: begin
        carry_nx = add_c;
        if (last) state_nx = ST_DRAIN;
      end
      ST_DRAIN: if (out_fire && last) state_nx = ST_LOAD;
      default: state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_LOAD;
      idx <= '0;
      carry <= 1'b0;
      for (int i = 0; i < N_CHUNKS; i++) begin
        buf_a[i] <= '0;
        buf_b[i] <= '0;
      end
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      carry <= carry_nx;
      if (in_fire) begin
        buf_a[idx] <= a_chunk;
        buf_b[idx] <= b_chunk;
      end else if (state == ST_ADD) begin
        buf_a[idx] <= add_s;
      end
    end
  end
endmodule

// File: tb/tb_chunk_add_sequencer.sv
// tb_chunk_add_sequencer: directed and random checks against an operand-level model
module tb_chunk_add_sequencer;
  localparam int W = 3;
  localparam int N = 4;
  localparam int TW = N * W + 1;
  logic clock = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [W-1:0] a_chunk = 0, b_chunk = 0;
  logic in_ready, out_valid, out_last, carry_out, busy;
  logic [W-1:0] sum_chunk;
  int total = 0, bad = 0;

  chunk_add_sequencer #(.CHUNK_W(W), .N_CHUNKS(N)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_chunk(a_chunk), .b_chunk(b_chunk), .out_valid(out_valid), .out_ready(out_ready),
    .sum_chunk(sum_chunk), .out_last(out_last), .carry_out(carry_out), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  logic [TW-1:0] m_q[$];
  logic [TW-1:0] m_a = 0, m_b = 0;
  int m_cnt = 0, m_oidx = 0, m_wait = 0;

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_sum", int'(sum_chunk), 0);
      chk("rst_last", int'(out_last), 0);
      chk("rst_carry", int'(carry_out), 0);
      chk("rst_busy", int'(busy), 0);
      m_q.delete();
      m_a = 0; m_b = 0; m_cnt = 0; m_oidx = 0; m_wait = 0;
    end else begin
      automatic bit ev = m_wait == 0 && m_q.size() > 0;
      chk("in_ready", int'(in_ready), int'(m_q.size() == 0));
      chk("out_valid", int'(out_valid), int'(ev));
      chk("busy", int'(busy), int'(m_cnt != 0 || m_q.size() > 0));
      if (ev) begin
        chk("sum_chunk", int'(sum_chunk), int'((m_q[0] >> (W * m_oidx)) & TW'(7)));
        chk("out_last", int'(out_last), int'(m_oidx == N - 1));
        chk("carry_out", int'(carry_out), (m_oidx == N - 1) ? int'(m_q[0][N*W]) : 0);
      end else begin
        chk("idle_sum", int'(sum_chunk), 0);
        chk("idle_last", int'(out_last), 0);
        chk("idle_carry", int'(carry_out), 0);
      end
      if (m_wait > 0) m_wait--;
      if (in_valid && in_ready) begin
        m_a = m_a | (TW'(a_chunk) << (W * m_cnt));
        m_b = m_b | (TW'(b_chunk) << (W * m_cnt));
        m_cnt++;
        if (m_cnt == N) begin
          m_q.push_back(m_a + m_b);
          m_wait = N;
          m_a = 0; m_b = 0; m_cnt = 0;
        end
      end
      if (out_valid && out_ready && ev) begin
        m_oidx++;
        if (m_oidx == N) begin
          m_oidx = 0;
          void'(m_q.pop_front());
        end
      end
    end
  end

  task automatic load(input logic [N*W-1:0] a, input logic [N*W-1:0] b, input int gapmode, input bit junk);
    for (int i = 0; i < N; i++) begin
      automatic int gaps = (i == 0) ? 0 : (gapmode == 1) ? 1 : (gapmode == 2) ? $urandom_range(0, 2) : 0;
      automatic bit fired = 0;
      automatic int g = 0;
      in_valid = 0;
      a_chunk = W'($urandom);
      b_chunk = W'($urandom);
      repeat (gaps) begin
        @(posedge clock); #1;
      end
      in_valid = 1;
      a_chunk = a[W*i +: W];
      b_chunk = b[W*i +: W];
      out_ready = 1'($urandom_range(0, 1));
      while (!fired && g < 50) begin
        @(negedge clock);
        fired = in_ready;
        @(posedge clock); #1;
        g++;
      end
      if (!fired) chk("load_timeout", 0, 1);
    end
    in_valid = junk;
    a_chunk = junk ? 3'd7 : 3'd0;
    b_chunk = junk ? 3'd7 : 3'd0;
  endtask

  task automatic drain(input int stall_idx, input int stall_n, input bit rnd,
                       output logic [N*W-1:0] sum, output logic cy,
                       output int lat_v, output int lat_l, output int stalled);
    int k = 0, n = 0;
    sum = 0; cy = 0; lat_v = -1; lat_l = -1; stalled = 0;
    while (k < N && n < 200) begin
      if (out_valid && k == stall_idx && stalled < stall_n) begin
        out_ready = 0;
        stalled++;
      end else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      n++;
      if (out_valid && lat_v < 0) lat_v = n;
      if (out_valid && out_ready) begin
        sum[W*k +: W] = sum_chunk;
        if (out_last) begin
          cy = carry_out;
          lat_l = n;
        end
        k++;
      end
      @(posedge clock); #1;
      if (k == N) begin
        in_valid = 0;
        a_chunk = 0;
        b_chunk = 0;
      end
    end
    if (k < N) chk("drain_timeout", k, N);
    out_ready = 0;
  endtask

  initial begin
    logic [N*W-1:0] s, a, b;
    logic cy;
    int lv, ll, ns;
    logic [TW-1:0] ref_sum;
    reset = 1;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_out_valid", int'(out_valid), 0);
    @(posedge clock); #1;

    load(12'o1234, 12'o4321, 0, 0);
    drain(-1, 0, 0, s, cy, lv, ll, ns);
    chk("t1_sum", int'(s), 12'o5555);
    chk("t1_carry", int'(cy), 0);
    chk("t1_first_valid_lat", lv, N + 1);
    chk("t1_last_lat", ll, 2 * N);

    load(12'o7777, 12'o0001, 0, 0);
    drain(-1, 0, 0, s, cy, lv, ll, ns);
    chk("t2_sum", int'(s), 0);
    chk("t2_carry", int'(cy), 1);
    chk("t2_last_lat", ll, 2 * N);

    load(12'o1234, 12'o4321, 0, 0);
    drain(1, 3, 0, s, cy, lv, ll, ns);
    chk("t3_sum", int'(s), 12'o5555);
    chk("t3_stalls", ns, 3);
    chk("t3_carry", int'(cy), 0);

    load(12'o1234, 12'o4321, 0, 1);
    drain(-1, 0, 0, s, cy, lv, ll, ns);
    chk("t4_sum", int'(s), 12'o5555);
    chk("t4_carry", int'(cy), 0);

    load(12'o5555, 12'o2222, 0, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    chk("t5_in_ready", int'(in_ready), 1);
    chk("t5_out_valid", int'(out_valid), 0);
    @(posedge clock); #1;
    load(12'o0003, 12'o0004, 0, 0);
    drain(-1, 0, 0, s, cy, lv, ll, ns);
    chk("t5_sum", int'(s), 12'o0007);
    chk("t5_carry", int'(cy), 0);

    load(12'o7000, 12'o1000, 1, 0);
    drain(-1, 0, 0, s, cy, lv, ll, ns);
    chk("t6_sum", int'(s), 0);
    chk("t6_carry", int'(cy), 1);

    repeat (40) begin
      a = 12'($urandom);
      b = 12'($urandom);
      ref_sum = TW'(a) + TW'(b);
      load(a, b, 2, 1'($urandom_range(0, 1)));
      drain($urandom_range(0, N - 1), $urandom_range(0, 3), 1, s, cy, lv, ll, ns);
      chk("rnd_sum", int'(s), int'(ref_sum[N*W-1:0]));
      chk("rnd_carry", int'(cy), int'(ref_sum[N*W]));
      chk("rnd_first_valid_lat", lv, N + 1);
    end

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
